// File: rtl/fsm_io_pkg.sv
// Shared constants, helpers and state encodings for the FSM/sequence-detector input front end.
//   SYS_CLK_TICK_DIV : default clk cycles per sample strobe
//   DEBOUNCE_DEFAULT : default debounce length in clk cycles
//   cnt_width()      : counter width able to hold 0..n-1
//   deb_state_e      : debouncer state encoding
package fsm_io_pkg;

    localparam int unsigned SYS_CLK_TICK_DIV = 40000000;
    localparam int unsigned DEBOUNCE_DEFAULT = 240000;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/bit_sampler_if.sv
// Signal bundle between the bit sampler and its consumer.
//   en, x_raw          : consumer -> sampler (tick enable, raw switch level)
//   x_out              : debounced level
//   sample_tick        : one-clk strobe per sample period
//   x_sample, history  : last sampled bit and shift history (bit 0 newest)
//   tick_led           : toggles on every strobe
interface bit_sampler_if #(
    parameter int unsigned HIST_W = 4
);
    logic              en;
    logic              x_raw;
    logic              x_out;
    logic              sample_tick;
    logic              x_sample;
    logic [HIST_W-1:0] history;
    logic              tick_led;

    modport master (
        output en,
        output x_raw,
        input  x_out,
        input  sample_tick,
        input  x_sample,
        input  history,
        input  tick_led
    );

    modport slave (
        input  en,
        input  x_raw,
        output x_out,
        output sample_tick,
        output x_sample,
        output history,
        output tick_led
    );
endinterface

// File: rtl/bit_sampler_debounce.sv
// Two-flop synchroniser followed by a counting debouncer.
//   clk, rst_n : clock, asynchronous active-low reset
//   x_raw      : asynchronous raw level
//   x_out      : registered debounced level; follows the synchronised input
//                only after it has differed for DEBOUNCE_CYCLES consecutive edges
module bit_debounce
    import fsm_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x_raw,
    output logic x_out
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("bit_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic             sync1_q;
    logic             sync2_q;
    logic             x_out_q;
    logic             x_out_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    deb_state_e       state_q;
    deb_state_e       state_d;

    logic differ_c;
    logic done_c;

    // The edge that first sees a difference is already a counting edge,
    // which gives the DEBOUNCE_CYCLES+2 step latency from x_raw.
    assign differ_c = (sync2_q != x_out_q);
    assign done_c   = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Synchroniser: the only flop that samples x_raw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= x_raw;
            sync2_q <= sync1_q;
        end
    end

    // State register with its counter and debounced output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            x_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_out_q <= x_out_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STABLE: begin
                if (differ_c) begin
                    state_d = COUNTING;
                end
            end
            COUNTING: begin
                if (!differ_c || done_c) begin
                    state_d = STABLE;
                end
            end
            default: state_d = STABLE;
        endcase
    end

    // Counter and output update; any return to agreement discards the count.
    always_comb begin
        cnt_d   = '0;
        x_out_d = x_out_q;
        if (differ_c) begin
            if (done_c) begin
                x_out_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign x_out = x_out_q;

endmodule

// File: rtl/bit_sampler.sv
// Input front end: debounced switch level plus a slow sample strobe that
// captures one clean bit per period into x_sample and a shift history.
//   clk, rst_n : system clock, asynchronous active-low reset
//   io.en      : tick enable; low holds the divider at 0
//   io.x_raw   : asynchronous raw switch level
//   io.x_out, io.sample_tick, io.x_sample, io.history, io.tick_led : registered outputs
module bit_sampler
    import fsm_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned TICK_DIV        = SYS_CLK_TICK_DIV,
    parameter int unsigned HIST_W          = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bit_sampler_if.slave  io
);

    localparam int unsigned TICK_W = cnt_width(TICK_DIV);

    if (TICK_DIV < 2) begin : g_bad_tick
        $error("bit_sampler: TICK_DIV must be >= 2");
    end
    if (HIST_W < 2) begin : g_bad_hist
        $error("bit_sampler: HIST_W must be >= 2");
    end

    logic [TICK_W-1:0] tick_cnt_q;
    logic              sample_tick_q;
    logic              x_sample_q;
    logic [HIST_W-1:0] history_q;
    logic              tick_led_q;
    logic              deb_x_out;
    logic              wrap_c;

    bit_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .x_raw (io.x_raw),
        .x_out (deb_x_out)
    );

    assign wrap_c = io.en && (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    // Sample period divider; the strobe is registered on the wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q    <= '0;
            sample_tick_q <= 1'b0;
        end else if (!io.en) begin
            tick_cnt_q    <= '0;
            sample_tick_q <= 1'b0;
        end else if (wrap_c) begin
            tick_cnt_q    <= '0;
            sample_tick_q <= 1'b1;
        end else begin
            tick_cnt_q    <= tick_cnt_q + TICK_W'(1);
            sample_tick_q <= 1'b0;
        end
    end

    // Capture on the wrap edge; reads the debounced level before any
    // same-edge update, so a coinciding change shows up one period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_sample_q <= 1'b0;
            history_q  <= '0;
            tick_led_q <= 1'b0;
        end else if (wrap_c) begin
            x_sample_q <= deb_x_out;
            history_q  <= {history_q[HIST_W-2:0], deb_x_out};
            tick_led_q <= ~tick_led_q;
        end
    end

    assign io.x_out       = deb_x_out;
    assign io.sample_tick = sample_tick_q;
    assign io.x_sample    = x_sample_q;
    assign io.history     = history_q;
    assign io.tick_led    = tick_led_q;

endmodule

// File: tb/tb_bit_sampler.sv
// Self-checking bench for bit_sampler: directed scenarios plus randomized
// stimulus, all compared against a window/run-length reference model.
module tb_bit_sampler;
    import fsm_io_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned TD  = 8;
    localparam int unsigned HW  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bit_sampler_if #(.HIST_W(HW)) bus();

    bit_sampler #(
        .DEBOUNCE_CYCLES (DEB),
        .TICK_DIV        (TD),
        .HIST_W          (HW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic          m_s1, m_s2, m_xout, m_tick, m_xs, m_led;
    logic [HW-1:0] m_hist;
    int unsigned   m_run;
    logic          m_win[$];

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_xout = 0; m_tick = 0; m_xs = 0; m_led = 0;
        m_hist = '0; m_run = 0;
        m_win.delete();
    endtask

    // One rising edge: x_out follows once the last DEB values seen after
    // the 2-edge synchroniser all disagree with it; a tick fires on every
    // TD-th consecutive enabled edge and captures the pre-edge level.
    task automatic model_step();
        logic seen, xo_old;
        bit   all_diff;
        seen   = m_s2;
        m_s2   = m_s1;
        m_s1   = bus.x_raw;
        xo_old = m_xout;
        m_win.push_back(seen);
        if (m_win.size() > DEB) void'(m_win.pop_front());
        all_diff = (m_win.size() == DEB);
        foreach (m_win[i]) if (m_win[i] == m_xout) all_diff = 0;
        if (all_diff) m_xout = seen;
        m_run  = bus.en ? m_run + 1 : 0;
        m_tick = bus.en && (m_run % TD == 0);
        if (m_tick) begin
            m_xs   = xo_old;
            m_hist = {m_hist[HW-2:0], xo_old};
            m_led  = ~m_led;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic e, input logic r);
        bus.en    = e;
        bus.x_raw = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic e, input logic r);
        rst_n     = 1'b0;
        bus.en    = e;
        bus.x_raw = r;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; bus.en = 1'b1; bus.x_raw = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led} !== 8'h00) begin
                bad++;
                $display("FAIL reset_hold: got %b want 00000000",
                         {bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led});
            end
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            cycle(1'b1, 1'b1);
            total++;
            if (bus.sample_tick !== ((n == 8) || (n == 16))) begin
                bad++;
                $display("FAIL first_tick edge %0d: got %b want %b", n, bus.sample_tick, (n == 8) || (n == 16));
            end
            total++;
            if ({bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led} !==
                {m_xout, m_tick, m_xs, m_hist, m_led}) begin
                bad++;
                $display("FAIL reset_model edge %0d: got %b want %b", n,
                         {bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led},
                         {m_xout, m_tick, m_xs, m_hist, m_led});
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset(1'b1, 1'b0);
        for (int n = 0; n < 18; n++) begin
            cycle(1'b1, (n >= 5) && (n < 8));
            total++;
            if (bus.x_out !== 1'b0 || bus.x_out !== m_xout) begin
                bad++;
                $display("FAIL glitch x_out cycle %0d: got %b want 0 (model %b)", n, bus.x_out, m_xout);
            end
        end
        total++;
        if (dut.u_debounce.state_q !== STABLE || dut.u_debounce.cnt_q !== '0) begin
            bad++;
            $display("FAIL glitch_idle: got state=%b cnt=%0d want state=0 cnt=0",
                     dut.u_debounce.state_q, dut.u_debounce.cnt_q);
        end
    endtask

    task automatic test_step();
        apply_reset(1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            cycle(1'b1, 1'b1);
            total++;
            if (bus.x_out !== (n >= 6) || bus.x_out !== m_xout) begin
                bad++;
                $display("FAIL step_rise edge %0d: got %b want %b", n, bus.x_out, n >= 6);
            end
        end
        for (int n = 1; n <= 8; n++) begin
            cycle(1'b1, 1'b0);
            total++;
            if (bus.x_out !== (n < 6) || bus.x_out !== m_xout) begin
                bad++;
                $display("FAIL step_fall edge %0d: got %b want %b", n, bus.x_out, n < 6);
            end
        end
    endtask

    task automatic test_history();
        logic prev_led;
        int   toggles;
        apply_reset(1'b1, 1'b0);
        prev_led = 1'b0;
        toggles  = 0;
        for (int n = 1; n <= 32; n++) begin
            cycle(1'b1, (n >= 17) && (n < 25));
            if (bus.tick_led !== prev_led) toggles++;
            prev_led = bus.tick_led;
            total++;
            if ({bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led} !==
                {m_xout, m_tick, m_xs, m_hist, m_led}) begin
                bad++;
                $display("FAIL history_model edge %0d: got %b want %b", n,
                         {bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led},
                         {m_xout, m_tick, m_xs, m_hist, m_led});
            end
        end
        total++;
        if (bus.history !== 4'b0010 || bus.x_sample !== 1'b0 || bus.tick_led !== 1'b0 || toggles != 4) begin
            bad++;
            $display("FAIL history_final: got hist=%b xs=%b led=%b toggles=%0d want 0010 0 0 4",
                     bus.history, bus.x_sample, bus.tick_led, toggles);
        end
    endtask

    task automatic test_enable();
        apply_reset(1'b1, 1'b0);
        repeat (5) cycle(1'b1, 1'b0);
        for (int n = 0; n < 20; n++) begin
            cycle(1'b0, 1'b0);
            total++;
            if (bus.sample_tick !== 1'b0) begin
                bad++;
                $display("FAIL enable_low cycle %0d: got tick=%b want 0", n, bus.sample_tick);
            end
        end
        for (int n = 1; n <= 10; n++) begin
            cycle(1'b1, 1'b0);
            total++;
            if (bus.sample_tick !== (n == 8) || bus.sample_tick !== m_tick) begin
                bad++;
                $display("FAIL enable_resume edge %0d: got tick=%b want %b", n, bus.sample_tick, n == 8);
            end
        end
    endtask

    task automatic test_collision();
        apply_reset(1'b1, 1'b0);
        for (int n = 1; n <= 24; n++) begin
            cycle(1'b1, n >= 11);
            if (n == 16) begin
                total++;
                if (bus.sample_tick !== 1'b1 || bus.x_sample !== 1'b0 || bus.x_out !== 1'b1) begin
                    bad++;
                    $display("FAIL collision_wrap: got tick=%b xs=%b xo=%b want 1 0 1",
                             bus.sample_tick, bus.x_sample, bus.x_out);
                end
            end
            if (n == 24) begin
                total++;
                if (bus.sample_tick !== 1'b1 || bus.x_sample !== 1'b1) begin
                    bad++;
                    $display("FAIL collision_next: got tick=%b xs=%b want 1 1", bus.sample_tick, bus.x_sample);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset(1'b1, 1'b0);
        repeat (12) cycle(1'b1, 1'b1);
        total++;
        if (bus.x_out !== 1'b1 || bus.tick_led !== 1'b1 || bus.history !== 4'b0001) begin
            bad++;
            $display("FAIL async_pre: got xo=%b led=%b hist=%b want 1 1 0001",
                     bus.x_out, bus.tick_led, bus.history);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led} !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: got %b want 00000000",
                     {bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            cycle(1'b1, 1'b1);
            total++;
            if ({bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led} !==
                {m_xout, m_tick, m_xs, m_hist, m_led}) begin
                bad++;
                $display("FAIL async_after edge %0d: got %b want %b", n,
                         {bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led},
                         {m_xout, m_tick, m_xs, m_hist, m_led});
            end
        end
    endtask

    task automatic test_random();
        logic r, e;
        int   run_left;
        apply_reset(1'b1, 1'b0);
        r = 1'b0;
        run_left = 0;
        for (int n = 0; n < 600; n++) begin
            if (run_left == 0) begin
                r = ~r;
                run_left = int'($urandom_range(1, 7));
            end
            run_left--;
            e = ($urandom_range(0, 15) != 0);
            cycle(e, r);
            total++;
            if ({bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led} !==
                {m_xout, m_tick, m_xs, m_hist, m_led}) begin
                bad++;
                $display("FAIL random cycle %0d: got %b want %b", n,
                         {bus.x_out, bus.sample_tick, bus.x_sample, bus.history, bus.tick_led},
                         {m_xout, m_tick, m_xs, m_hist, m_led});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_glitch();
        test_step();
        test_history();
        test_enable();
        test_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_sampler.md
Name: bit_sampler

Overview:
- Input front end for the FSM/sequence-detector blocks.
- Takes a raw switch/button level, synchronises and debounces it, and divides the system clock into a slow sample strobe.
- Presents one clean bit per strobe, plus a short shift history for display.
- The downstream detector uses sample_tick as its clock enable on clk; it does not run on a derived clock.

Parameters:
- DEBOUNCE_CYCLES, 240000: consecutive clk cycles the synchronised input must differ from x_out before x_out follows it; must be >=2.
- TICK_DIV, 40000000: clk cycles per sample_tick; must be >=2.
- HIST_W, 4: number of sampled bits kept in history; must be >=2.

Ports:
- clk  input  1  system clock (Sys_Clk0 domain)
- rst_n  input  1  asynchronous active-low reset
- en  input  1  tick enable; 0 holds the divider at 0
- x_raw  input  1  asynchronous raw switch level
- x_out  output  1  debounced level
- sample_tick  output  1  one-clk pulse per sample period
- x_sample  output  1  bit captured at the last sample_tick
- history  output  HIST_W  last HIST_W sampled bits; bit 0 is newest
- tick_led  output  1  toggles on every sample_tick

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- While rst_n=0, all state and outputs are 0: sync flops, debounce counter, x_out, tick counter, sample_tick, x_sample, history, tick_led.
- Reset has immediate effect mid-operation; any partial count is discarded.
- Synchroniser: 2 flops, sync1 <= x_raw, sync2 <= sync1. Nothing else samples x_raw.
- Debouncer FSM, 2 states:
  - STABLE: sync2 == x_out, counter = 0.
  - COUNTING: sync2 != x_out.
  - Each COUNTING edge: if cnt == DEBOUNCE_CYCLES-1, then x_out <= sync2, cnt <= 0, go to STABLE; else cnt++.
  - If sync2 returns to x_out while COUNTING: cnt <= 0, go to STABLE, x_out unchanged.
  - Counter width: clog2(DEBOUNCE_CYCLES).
- Debounce latency: for a clean x_raw step, x_out changes on the (DEBOUNCE_CYCLES+2)th rising edge. The first edge that captures the new x_raw counts as edge 1.
- Glitch rejection: any glitch shorter than DEBOUNCE_CYCLES cycles at sync2 leaves x_out unchanged.
- Tick divider:
  - Width clog2(TICK_DIV); counts 0..TICK_DIV-1 while en=1.
  - At TICK_DIV-1 it wraps to 0, and sample_tick is registered high for exactly the following cycle.
  - First tick after reset release with en=1: sample_tick is high after the TICK_DIV-th edge.
  - en=0: counter is synchronously cleared to 0 and no ticks occur. When en returns to 1, counting restarts from 0.
  - en=0 does not affect the debouncer.
- Sample capture, on the same edge the divider wraps:
  - x_sample <= x_out
  - history <= {history[HIST_W-2:0], x_out}
  - tick_led <= ~tick_led
  - All three update together with the rising of sample_tick.
- Simultaneous debounce update and divider wrap: capture uses the pre-update x_out. The new value appears at the next tick.
- No combinational path from any input to any output.

Decomposition:
- Shared package fsm_io_pkg:
  - default constants SYS_CLK_TICK_DIV = 40000000 and DEBOUNCE_DEFAULT = 240000;
  - a clog2-based counter-width function;
  - the debouncer state encoding STABLE=1'b0, COUNTING=1'b1.
- One sub-module: bit_debounce (synchroniser + debouncer FSM, parameter DEBOUNCE_CYCLES, ports clk, rst_n, x_raw, x_out).
- The divider and capture logic stay in bit_sampler.
- Parameter legality is checked by elaboration-time assertions.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=8, HIST_W=4):
1. Reset/first tick: hold rst_n=0 with x_raw=1, then release with en=1 -> all outputs 0 during reset; first sample_tick is high after edge 8 and again after edge 16.
2. Glitch: x_raw 0->1 for 3 cycles, then 0 -> x_out stays 0 throughout; debouncer returns to STABLE with cnt=0.
3. Clean step: x_raw 0->1 held -> x_out becomes 1 after edge 6; 1->0 held -> x_out becomes 0 after 6 more edges.
4. History: drive x_out to 0,0,1,0 across four consecutive ticks -> history=4'b0010, x_sample=0, tick_led toggles 4 times and ends at 0.
5. Enable gating: drop en at divider count 5, hold it low for 20 cycles, then raise it -> no sample_tick while low; next tick after edge 8 post-raise.
6. Collision and async reset:
   - Time x_out's 0->1 update onto the divider-wrap edge -> x_sample=0 at that tick, 1 at the next.
   - Pulse rst_n low mid-count -> all outputs 0 immediately, without waiting for a clk edge.
